// File: rtl/cordic_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cordic_sequencer_pkg
//   Shared CORDIC constants. These are used by the sequencer and by the
//   datapath, whose atan table depth follows the iteration count.
//   Contents:
//     CORDIC_N_ITER    - default number of micro-rotations per sample
//     CORDIC_BW_ITER   - default width of the iteration index
//     ATAN_TABLE_DEPTH - number of atan table entries the datapath holds
//     ST_*             - sequencer state encodings
// ---------------------------------------------------------------------------
package cordic_sequencer_pkg;

    localparam int CORDIC_N_ITER    = 7;
    localparam int CORDIC_BW_ITER   = 4;
    localparam int ATAN_TABLE_DEPTH = CORDIC_N_ITER;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ITER  = 3'd2;
    localparam logic [STATE_W-1:0] ST_LATCH = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/cordic_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_sequencer
//   Control FSM for an iterative CORDIC datapath. For each accepted sample
//   strobe it loads the datapath, runs N_ITER micro-rotations, latches the
//   result and holds it valid until the consumer accepts it. A strobe that
//   arrives while the FSM cannot accept it is dropped, and this raises a
//   sticky overrun flag.
//
//   Ports:
//     clk_i      in   clock; all state changes on its rising edge
//     rst_i      in   synchronous active-low reset
//     enable_i   in   allows new samples to start; low clears overrun_o
//     strobe_i   in   one-cycle sample-rate tick
//     ready_i    in   downstream accepts the held result
//     load_o     out  load datapath x/y/z with a new sample
//     iter_en_o  out  perform one micro-rotation this cycle
//     iter_idx_o out  shift amount / atan index (0 when iter_en_o=0)
//     latch_o    out  capture the datapath result into the output register
//     valid_o    out  output register holds an unconsumed result
//     busy_o     out  FSM is not idle
//     overrun_o  out  sticky: a strobe was dropped while enabled
//
//   All outputs are decoded from the state, counter and overrun registers,
//   so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module cordic_sequencer
    import cordic_sequencer_pkg::*;
#(
    parameter int N_ITER  = CORDIC_N_ITER,
    parameter int BW_ITER = CORDIC_BW_ITER
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               strobe_i,
    input  logic               ready_i,
    output logic               load_o,
    output logic               iter_en_o,
    output logic [BW_ITER-1:0] iter_idx_o,
    output logic               latch_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam logic [BW_ITER-1:0] LAST_IDX = BW_ITER'(N_ITER - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [BW_ITER-1:0] cnt;
    logic [BW_ITER-1:0] cnt_next;
    logic               overrun;
    logic               overrun_next;

    // A sample can start from IDLE, or directly from HOLD in the same cycle
    // that the consumer takes the previous result. This lets a strobe period
    // of N_ITER+3 run without overrun.
    logic start_req;
    logic can_accept;
    logic dropped;

    assign start_req  = strobe_i & enable_i;
    assign can_accept = (state == ST_IDLE) | ((state == ST_HOLD) & ready_i);
    assign dropped    = start_req & ~can_accept;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned (no latch inferred).
        state_next = state;
        cnt_next   = '0;
        case (state)
            ST_IDLE: begin
                if (start_req) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_ITER;
            end
            ST_ITER: begin
                if (cnt == LAST_IDX) begin
                    state_next = ST_LATCH;
                end else begin
                    cnt_next = cnt + BW_ITER'(1);
                end
            end
            ST_LATCH: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (ready_i) state_next = start_req ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Dropping enable clears the flag. Otherwise the flag holds and
    // accumulates dropped strobes.
    assign overrun_next = enable_i ? (overrun | dropped) : 1'b0;

    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge (synchronous). State is
        // updated with non-blocking assignments so all registers see
        // pre-edge values.
        if (!rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            overrun <= overrun_next;
        end
    end

    assign load_o     = (state == ST_LOAD);
    assign iter_en_o  = (state == ST_ITER);
    assign iter_idx_o = iter_en_o ? cnt : '0;
    assign latch_o    = (state == ST_LATCH);
    assign valid_o    = (state == ST_HOLD);
    assign busy_o     = (state != ST_IDLE);
    assign overrun_o  = overrun;

endmodule

// File: tb/tb_cordic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cordic_sequencer
//   Self-checking bench for cordic_sequencer. A reference model follows the
//   sample timeline as a single "cycles since load" phase and predicts every
//   output on every cycle. Directed scenarios are followed by a randomized
//   run.
// ---------------------------------------------------------------------------
module tb_cordic_sequencer;

    localparam int N  = 7;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          strobe = 1'b0;
    logic          ready = 1'b0;
    logic          load;
    logic          iter_en;
    logic [BW-1:0] iter_idx;
    logic          latch;
    logic          valid;
    logic          busy;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model. Phase -1 means idle. Phase 0 is the load cycle,
    // phases 1..N are the rotations, phase N+1 is the latch cycle, and
    // phase N+2 is the wait for the consumer.
    int   m_phase = -1;
    logic m_ovr   = 1'b0;

    cordic_sequencer #(
        .N_ITER (N),
        .BW_ITER(BW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable),
        .strobe_i  (strobe),
        .ready_i   (ready),
        .load_o    (load),
        .iter_en_o (iter_en),
        .iter_idx_o(iter_idx),
        .latch_o   (latch),
        .valid_o   (valid),
        .busy_o    (busy),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic s, input logic e, input logic r, input logic rs);
        bit idle;
        bit waiting;
        bit accept;
        bit drop;
        if (!rs) begin
            m_phase = -1;
            m_ovr   = 1'b0;
        end else begin
            idle    = (m_phase < 0);
            waiting = (m_phase == N + 2);
            accept  = s && e && (idle || (waiting && r));
            drop    = s && e && !accept;
            if (!e)        m_ovr = 1'b0;
            else if (drop) m_ovr = 1'b1;
            if (accept)       m_phase = 0;
            else if (idle)    m_phase = -1;
            else if (waiting) m_phase = r ? -1 : m_phase;
            else              m_phase = m_phase + 1;
        end
    endtask

    task automatic check_outputs();
        bit   e_iter;
        int   e_idx;
        e_iter = (m_phase >= 1) && (m_phase <= N);
        e_idx  = e_iter ? m_phase - 1 : 0;
        check("load",     32'(load),     32'(m_phase == 0));
        check("iter_en",  32'(iter_en),  32'(e_iter));
        check("iter_idx", 32'(iter_idx), 32'(e_idx));
        check("latch",    32'(latch),    32'(m_phase == N + 1));
        check("valid",    32'(valid),    32'(m_phase == N + 2));
        check("busy",     32'(busy),     32'(m_phase >= 0));
        check("overrun",  32'(overrun),  32'(m_ovr));
    endtask

    // Drive one cycle of inputs, clock it, then check outputs 1 ns later.
    task automatic step(input logic s, input logic e, input logic r, input logic rs);
        strobe = s;
        enable = e;
        ready  = r;
        rst    = rs;
        @(posedge clk);
        model_update(s, e, r, rs);
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset, with a strobe during reset that must not start a sample.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Single sample with ready tied high.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("s1_load", 32'(load), 32'd1);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("s1_iter_en", 32'(iter_en), 32'd1);
            check("s1_iter_idx", 32'(iter_idx), 32'(i));
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("s1_latch", 32'(latch), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("s1_valid", 32'(valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("s1_idle", 32'(busy), 32'd0);

        // Back-to-back samples at the minimum period N+3.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            check("b2b_load", 32'(load), 32'd1);
            for (int i = 0; i < N + 2; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("b2b_ovr", 32'(overrun), 32'd0);
        check("b2b_idle", 32'(busy), 32'd0);

        // Dropped strobe: a period of 6 cycles, then one cycle with enable low.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("drop_ovr_before", 32'(overrun), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("drop_ovr_set", 32'(overrun), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("drop_ovr_sticky", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("drop_ovr_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < N + 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("drop_idle", 32'(busy), 32'd0);

        // Backpressure: ready low for 5 cycles after valid, strobe in between.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < N + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("bp_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step((i == 2), 1'b1, 1'b0, 1'b1);
            check("bp_valid_held", 32'(valid), 32'd1);
            check("bp_no_load", 32'(load), 32'd0);
        end
        check("bp_ovr", 32'(overrun), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("bp_idle", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("bp_ovr_clr", 32'(overrun), 32'd0);

        // Reset in the middle of the rotations, at index 3.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("mid_idx3", 32'(iter_idx), 32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("mid_rst_outs",
              32'({load, iter_en, iter_idx, latch, valid, busy, overrun}), 32'd0);
        for (int i = 0; i < N + 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("mid_no_latch", 32'(latch), 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 6) == 0, ($urandom % 25) != 0,
                 ($urandom % 4) != 0, ($urandom % 300) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
